// File: rtl/tag_rx_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tag_rx_sweep_ctrl_pkg
//   Shared definitions for the tag RX chirp phase sequencer:
//   FSM state encoding, configuration register addresses and the values
//   the configuration bank returns to on reset.
// ---------------------------------------------------------------------------
package tag_rx_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

    localparam logic [2:0] CFG_ADDR_START_PH     = 3'd0;
    localparam logic [2:0] CFG_ADDR_START_PH_INC = 3'd1;
    localparam logic [2:0] CFG_ADDR_DPH_INC      = 3'd2;
    localparam logic [2:0] CFG_ADDR_NSIG         = 3'd3;
    localparam logic [2:0] CFG_ADDR_NSYMB        = 3'd4;
    localparam logic [2:0] CFG_ADDR_NPH_SHIFT    = 3'd5;
    localparam logic [2:0] CFG_ADDR_NLOC         = 3'd6;
    localparam logic [2:0] CFG_ADDR_GAP          = 3'd7;

    // Defaults are 32-bit and truncated to the field width where used.
    // DEF_DPH_INC is -131072 in two's complement.
    localparam logic [31:0] DEF_START_PH     = 32'd0;
    localparam logic [31:0] DEF_START_PH_INC = 32'd4194304;
    localparam logic [31:0] DEF_DPH_INC      = 32'hFFFE_0000;
    localparam logic [31:0] DEF_NSIG         = 32'd262144;
    localparam logic [31:0] DEF_NSYMB        = 32'd64;
    localparam logic [31:0] DEF_NPH_SHIFT    = 32'd0;
    localparam logic [31:0] DEF_NLOC         = 32'd7;
    localparam logic [31:0] DEF_GAP          = 32'd0;

endpackage

// File: rtl/tag_rx_sweep_ctrl_cfg.sv
// ---------------------------------------------------------------------------
// tag_rx_sweep_ctrl_cfg
//   Shadow/active configuration bank for the sweep sequencer.
//   Writes always land in the shadow bank. The active bank is copied from
//   the shadow bank when 'latch' is high (an accepted start); count fields
//   of zero are stored as one so the sequencer never sees an empty loop.
//   The outputs are a "launch view": on the latch cycle they already show
//   the values about to become active, so the top can load its accumulators
//   in the same cycle it accepts start.
// Ports
//   clk, clear                 clock, synchronous clear to defaults
//   cfg_wr/cfg_addr/cfg_data   register write port
//   latch                      copy shadow -> active this cycle
//   start_ph .. gap            current view of the sweep configuration
// ---------------------------------------------------------------------------
module tag_rx_sweep_ctrl_cfg
    import tag_rx_sweep_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = 24,
    parameter int NSIG_WIDTH  = 24,
    parameter int NSYMB_WIDTH = 16,
    parameter int NLOC_WIDTH  = 3,
    parameter int GAP_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   cfg_wr,
    input  logic [2:0]             cfg_addr,
    input  logic [31:0]            cfg_data,
    input  logic                   latch,
    output logic [PHASE_WIDTH-1:0] start_ph,
    output logic [PHASE_WIDTH-1:0] start_ph_inc,
    output logic [PHASE_WIDTH-1:0] dph_inc,
    output logic [PHASE_WIDTH-1:0] nph_shift,
    output logic [NSIG_WIDTH-1:0]  nsig,
    output logic [NSYMB_WIDTH-1:0] nsymb,
    output logic [NLOC_WIDTH-1:0]  nloc,
    output logic [GAP_WIDTH-1:0]   gap
);

    logic [PHASE_WIDTH-1:0] sh_start_ph_reg, sh_start_ph_inc_reg, sh_dph_inc_reg, sh_nph_shift_reg;
    logic [NSIG_WIDTH-1:0]  sh_nsig_reg;
    logic [NSYMB_WIDTH-1:0] sh_nsymb_reg;
    logic [NLOC_WIDTH-1:0]  sh_nloc_reg;
    logic [GAP_WIDTH-1:0]   sh_gap_reg;

    logic [PHASE_WIDTH-1:0] act_start_ph_reg, act_start_ph_inc_reg, act_dph_inc_reg, act_nph_shift_reg;
    logic [NSIG_WIDTH-1:0]  act_nsig_reg;
    logic [NSYMB_WIDTH-1:0] act_nsymb_reg;
    logic [NLOC_WIDTH-1:0]  act_nloc_reg;
    logic [GAP_WIDTH-1:0]   act_gap_reg;

    logic [NSIG_WIDTH-1:0]  sh_nsig_min1;
    logic [NSYMB_WIDTH-1:0] sh_nsymb_min1;
    logic [NLOC_WIDTH-1:0]  sh_nloc_min1;

    // Upper data bits beyond each field width are intentionally dropped.
    logic unused_cfg_data;
    assign unused_cfg_data = ^cfg_data;

    assign sh_nsig_min1  = (sh_nsig_reg  == '0) ? NSIG_WIDTH'(1)  : sh_nsig_reg;
    assign sh_nsymb_min1 = (sh_nsymb_reg == '0) ? NSYMB_WIDTH'(1) : sh_nsymb_reg;
    assign sh_nloc_min1  = (sh_nloc_reg  == '0) ? NLOC_WIDTH'(1)  : sh_nloc_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            sh_start_ph_reg     <= PHASE_WIDTH'(DEF_START_PH);
            sh_start_ph_inc_reg <= PHASE_WIDTH'(DEF_START_PH_INC);
            sh_dph_inc_reg      <= PHASE_WIDTH'(DEF_DPH_INC);
            sh_nph_shift_reg    <= PHASE_WIDTH'(DEF_NPH_SHIFT);
            sh_nsig_reg         <= NSIG_WIDTH'(DEF_NSIG);
            sh_nsymb_reg        <= NSYMB_WIDTH'(DEF_NSYMB);
            sh_nloc_reg         <= NLOC_WIDTH'(DEF_NLOC);
            sh_gap_reg          <= GAP_WIDTH'(DEF_GAP);
        end else if (cfg_wr) begin
            case (cfg_addr)
                CFG_ADDR_START_PH:     sh_start_ph_reg     <= cfg_data[PHASE_WIDTH-1:0];
                CFG_ADDR_START_PH_INC: sh_start_ph_inc_reg <= cfg_data[PHASE_WIDTH-1:0];
                CFG_ADDR_DPH_INC:      sh_dph_inc_reg      <= cfg_data[PHASE_WIDTH-1:0];
                CFG_ADDR_NSIG:         sh_nsig_reg         <= cfg_data[NSIG_WIDTH-1:0];
                CFG_ADDR_NSYMB:        sh_nsymb_reg        <= cfg_data[NSYMB_WIDTH-1:0];
                CFG_ADDR_NPH_SHIFT:    sh_nph_shift_reg    <= cfg_data[PHASE_WIDTH-1:0];
                CFG_ADDR_NLOC:         sh_nloc_reg         <= cfg_data[NLOC_WIDTH-1:0];
                CFG_ADDR_GAP:          sh_gap_reg          <= cfg_data[GAP_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            act_start_ph_reg     <= PHASE_WIDTH'(DEF_START_PH);
            act_start_ph_inc_reg <= PHASE_WIDTH'(DEF_START_PH_INC);
            act_dph_inc_reg      <= PHASE_WIDTH'(DEF_DPH_INC);
            act_nph_shift_reg    <= PHASE_WIDTH'(DEF_NPH_SHIFT);
            act_nsig_reg         <= NSIG_WIDTH'(DEF_NSIG);
            act_nsymb_reg        <= NSYMB_WIDTH'(DEF_NSYMB);
            act_nloc_reg         <= NLOC_WIDTH'(DEF_NLOC);
            act_gap_reg          <= GAP_WIDTH'(DEF_GAP);
        end else if (latch) begin
            act_start_ph_reg     <= sh_start_ph_reg;
            act_start_ph_inc_reg <= sh_start_ph_inc_reg;
            act_dph_inc_reg      <= sh_dph_inc_reg;
            act_nph_shift_reg    <= sh_nph_shift_reg;
            act_nsig_reg         <= sh_nsig_min1;
            act_nsymb_reg        <= sh_nsymb_min1;
            act_nloc_reg         <= sh_nloc_min1;
            act_gap_reg          <= sh_gap_reg;
        end
    end

    assign start_ph     = latch ? sh_start_ph_reg     : act_start_ph_reg;
    assign start_ph_inc = latch ? sh_start_ph_inc_reg : act_start_ph_inc_reg;
    assign dph_inc      = latch ? sh_dph_inc_reg      : act_dph_inc_reg;
    assign nph_shift    = latch ? sh_nph_shift_reg    : act_nph_shift_reg;
    assign nsig         = latch ? sh_nsig_min1        : act_nsig_reg;
    assign nsymb        = latch ? sh_nsymb_min1       : act_nsymb_reg;
    assign nloc         = latch ? sh_nloc_min1        : act_nloc_reg;
    assign gap          = latch ? sh_gap_reg          : act_gap_reg;

endmodule

// File: rtl/tag_rx_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tag_rx_sweep_ctrl
//   Chirp phase sequencer for the tag RX downconverter DDS.
//   Emits NLOC x NSYMB x NSIG phase words on an AXI-Stream style interface.
//   Sample k of symbol s carries
//       start_ph - s*nph_shift + k*(start_ph_inc + s*dph_inc)   (mod 2^PHASE_WIDTH)
//   built incrementally from three accumulators: current phase, current
//   per-sample increment and current symbol base.
// Ports
//   clk, reset_n, srst          clock; sync active-low reset; sync active-high clear
//   cfg_wr/cfg_addr/cfg_data    configuration writes (shadow bank)
//   start, stop                 launch sweep (IDLE only); graceful abort at next tlast
//   busy                        high while SWEEP/GAP/DONE
//   phase_tdata/tvalid/tready/tlast   phase stream, tlast marks last sample of a symbol
//   symb_idx, loc_idx           indices of the beat currently on tdata
//   sync_ready                  pulse on the tlast beat of each location's last symbol
//   done                        pulse on the final beat of a completed (not aborted) sweep
// ---------------------------------------------------------------------------
module tag_rx_sweep_ctrl
    import tag_rx_sweep_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = 24,
    parameter int NSIG_WIDTH  = 24,
    parameter int NSYMB_WIDTH = 16,
    parameter int NLOC_WIDTH  = 3,
    parameter int GAP_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   srst,
    input  logic                   cfg_wr,
    input  logic [2:0]             cfg_addr,
    input  logic [31:0]            cfg_data,
    input  logic                   start,
    input  logic                   stop,
    output logic                   busy,
    output logic [PHASE_WIDTH-1:0] phase_tdata,
    output logic                   phase_tvalid,
    input  logic                   phase_tready,
    output logic                   phase_tlast,
    output logic [NSYMB_WIDTH-1:0] symb_idx,
    output logic [NLOC_WIDTH-1:0]  loc_idx,
    output logic                   sync_ready,
    output logic                   done
);

    localparam logic [NSIG_WIDTH-1:0]  NSIG_ONE  = NSIG_WIDTH'(1);
    localparam logic [NSYMB_WIDTH-1:0] NSYMB_ONE = NSYMB_WIDTH'(1);
    localparam logic [NLOC_WIDTH-1:0]  NLOC_ONE  = NLOC_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0]   GAP_ONE   = GAP_WIDTH'(1);

    logic clear;
    assign clear = !reset_n || srst;

    sweep_state_t state_reg, state_next;

    logic [PHASE_WIDTH-1:0] phase_reg, inc_reg, base_reg;
    logic [NSIG_WIDTH-1:0]  samp_reg;
    logic [NSYMB_WIDTH-1:0] symb_reg;
    logic [NLOC_WIDTH-1:0]  loc_reg;
    logic [GAP_WIDTH-1:0]   gap_cnt_reg;
    logic                   stop_pend_reg;

    logic [PHASE_WIDTH-1:0] c_start_ph, c_start_ph_inc, c_dph_inc, c_nph_shift;
    logic [NSIG_WIDTH-1:0]  c_nsig;
    logic [NSYMB_WIDTH-1:0] c_nsymb;
    logic [NLOC_WIDTH-1:0]  c_nloc;
    logic [GAP_WIDTH-1:0]   c_gap;

    logic latch, beat, last_samp, last_symb, last_loc, stop_now, sym_end;

    // start is only accepted from IDLE; a simultaneous stop is simply not latched.
    assign latch = (state_reg == ST_IDLE) && start;

    tag_rx_sweep_ctrl_cfg #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .NSIG_WIDTH  (NSIG_WIDTH),
        .NSYMB_WIDTH (NSYMB_WIDTH),
        .NLOC_WIDTH  (NLOC_WIDTH),
        .GAP_WIDTH   (GAP_WIDTH)
    ) u_cfg (
        .clk          (clk),
        .clear        (clear),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .latch        (latch),
        .start_ph     (c_start_ph),
        .start_ph_inc (c_start_ph_inc),
        .dph_inc      (c_dph_inc),
        .nph_shift    (c_nph_shift),
        .nsig         (c_nsig),
        .nsymb        (c_nsymb),
        .nloc         (c_nloc),
        .gap          (c_gap)
    );

    assign beat      = (state_reg == ST_SWEEP) && phase_tready;
    assign last_samp = (samp_reg == c_nsig - NSIG_ONE);
    assign last_symb = (symb_reg == c_nsymb - NSYMB_ONE);
    assign last_loc  = (loc_reg == c_nloc - NLOC_ONE);
    // A stop arriving on the tlast beat itself is honoured on that beat.
    assign stop_now  = stop_pend_reg || stop;
    assign sym_end   = beat && last_samp;

    assign busy         = (state_reg != ST_IDLE);
    assign phase_tvalid = (state_reg == ST_SWEEP);
    assign phase_tdata  = phase_reg;
    assign phase_tlast  = (state_reg == ST_SWEEP) && last_samp;
    assign symb_idx     = symb_reg;
    assign loc_idx      = loc_reg;
    assign sync_ready   = sym_end && last_symb;
    assign done         = sym_end && last_symb && last_loc && !stop_now;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (sym_end) begin
                    if ((last_symb && last_loc) || stop_now) begin
                        state_next = ST_DONE;
                    end else if (c_gap != '0) begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (stop_now) begin
                    state_next = ST_DONE;
                end else if (gap_cnt_reg == GAP_ONE) begin
                    state_next = ST_SWEEP;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            phase_reg     <= '0;
            inc_reg       <= '0;
            base_reg      <= '0;
            samp_reg      <= '0;
            symb_reg      <= '0;
            loc_reg       <= '0;
            gap_cnt_reg   <= '0;
            stop_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        phase_reg     <= c_start_ph;
                        base_reg      <= c_start_ph;
                        inc_reg       <= c_start_ph_inc;
                        samp_reg      <= '0;
                        symb_reg      <= '0;
                        loc_reg       <= '0;
                        stop_pend_reg <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (stop) begin
                        stop_pend_reg <= 1'b1;
                    end
                    if (beat) begin
                        if (last_samp) begin
                            samp_reg    <= '0;
                            gap_cnt_reg <= c_gap;
                            if (last_symb) begin
                                // Next location restarts the symbol pattern.
                                symb_reg  <= '0;
                                inc_reg   <= c_start_ph_inc;
                                base_reg  <= c_start_ph;
                                phase_reg <= c_start_ph;
                                if (!last_loc) begin
                                    loc_reg <= loc_reg + NLOC_ONE;
                                end
                            end else begin
                                symb_reg  <= symb_reg + NSYMB_ONE;
                                inc_reg   <= inc_reg + c_dph_inc;
                                base_reg  <= base_reg - c_nph_shift;
                                phase_reg <= base_reg - c_nph_shift;
                            end
                        end else begin
                            samp_reg  <= samp_reg + NSIG_ONE;
                            phase_reg <= phase_reg + inc_reg;
                        end
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        stop_pend_reg <= 1'b1;
                    end
                    gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
                end
                ST_DONE: begin
                    stop_pend_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_rx_sweep_ctrl.sv
module tb_tag_rx_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        srst = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_data = 32'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        phase_tready = 1'b1;
    logic        busy, phase_tvalid, phase_tlast, sync_ready, done;
    logic [23:0] phase_tdata;
    logic [15:0] symb_idx;
    logic [2:0]  loc_idx;

    always #5 clk = ~clk;

    tag_rx_sweep_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .srst         (srst),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .start        (start),
        .stop         (stop),
        .busy         (busy),
        .phase_tdata  (phase_tdata),
        .phase_tvalid (phase_tvalid),
        .phase_tready (phase_tready),
        .phase_tlast  (phase_tlast),
        .symb_idx     (symb_idx),
        .loc_idx      (loc_idx),
        .sync_ready   (sync_ready),
        .done         (done)
    );

    typedef struct {
        logic [23:0] start_ph, inc, dph, nsh, nsig;
        logic [15:0] nsymb;
        logic [2:0]  nloc;
        logic [15:0] gap;
    } cfg_t;

    typedef struct {
        logic [23:0] ph;
        logic        last, sync, done;
        logic [15:0] symb;
        logic [2:0]  loc;
        int          idle;
    } beat_t;

    typedef struct {
        logic [23:0] ph;
        logic        last, sync, done;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    stray;
    beat_t got_q[$];
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic cfg_t def_cfg();
        cfg_t c;
        c.start_ph = 24'd0;
        c.inc      = 24'd4194304;
        c.dph      = 24'hFE0000;
        c.nsh      = 24'd0;
        c.nsig     = 24'd262144;
        c.nsymb    = 16'd64;
        c.nloc     = 3'd7;
        c.gap      = 16'd0;
        return c;
    endfunction

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic write_cfg(input cfg_t c);
        wr(3'd0, 32'(c.start_ph));
        wr(3'd1, 32'(c.inc));
        wr(3'd2, 32'(c.dph));
        wr(3'd3, 32'(c.nsig));
        wr(3'd4, 32'(c.nsymb));
        wr(3'd5, 32'(c.nsh));
        wr(3'd6, 32'(c.nloc));
        wr(3'd7, 32'(c.gap));
    endtask

    // Reference: enumerate every (loc, symbol, sample) and evaluate the
    // closed-form phase; a stop cuts the sweep at the end of its symbol.
    task automatic build_model(input cfg_t c, input int stop_at);
        int ns, nsy, nl, cut;
        longint unsigned sp, in, dp, sh, v, ls, lk;
        beat_t b;
        exp_q.delete();
        ns  = (c.nsig  == 0) ? 1 : int'(c.nsig);
        nsy = (c.nsymb == 0) ? 1 : int'(c.nsymb);
        nl  = (c.nloc  == 0) ? 1 : int'(c.nloc);
        sp = c.start_ph; in = c.inc; dp = c.dph; sh = c.nsh;
        for (int l = 0; l < nl; l++) begin
            for (int s = 0; s < nsy; s++) begin
                for (int k = 0; k < ns; k++) begin
                    ls = longint'(s); lk = longint'(k);
                    v = sp - ls * sh + lk * (in + ls * dp);
                    b.ph   = v[23:0];
                    b.last = (k == ns - 1);
                    b.sync = b.last && (s == nsy - 1);
                    b.done = b.sync && (l == nl - 1);
                    b.symb = 16'(s);
                    b.loc  = 3'(l);
                    b.idle = (k == 0 && (l != 0 || s != 0)) ? int'(c.gap) : 0;
                    exp_q.push_back(b);
                end
            end
        end
        if (stop_at >= 0) begin
            cut = (stop_at / ns + 1) * ns;
            while (exp_q.size() > cut) void'(exp_q.pop_back());
            foreach (exp_q[i]) exp_q[i].done = 1'b0;
        end
    endtask

    // Launch one sweep and record every beat until busy falls.
    task automatic run_sweep(input string tag, input bit rnd, input int stop_at, input bit mid_wr);
        int          cyc, idle;
        bit          stalled;
        logic [23:0] pd;
        logic        pl;
        beat_t       b;
        got_q.delete();
        stray = 0; idle = 0; stalled = 0; cyc = 0; pd = '0; pl = 1'b0;
        phase_tready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 3000) begin
            phase_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stop   = (stop_at >= 0) && (got_q.size() == stop_at) && phase_tvalid;
            cfg_wr = mid_wr && (cyc == 2);
            cfg_addr = 3'd3; cfg_data = 32'd2;
            #1;
            if (!busy) break;
            if (stalled) begin
                chk({tag, "_stall_valid"}, 64'(phase_tvalid), 64'd1);
                chk({tag, "_stall_data"},  64'(phase_tdata),  64'(pd));
                chk({tag, "_stall_last"},  64'(phase_tlast),  64'(pl));
            end
            if (phase_tvalid && phase_tready) begin
                b.ph = phase_tdata; b.last = phase_tlast; b.sync = sync_ready; b.done = done;
                b.symb = symb_idx; b.loc = loc_idx; b.idle = idle;
                got_q.push_back(b);
                idle = 0;
            end else begin
                if (!phase_tvalid) idle++;
                if (sync_ready || done) stray++;
            end
            stalled = phase_tvalid && !phase_tready;
            pd = phase_tdata; pl = phase_tlast;
            @(negedge clk);
            cyc++;
        end
        stop = 1'b0; cfg_wr = 1'b0; phase_tready = 1'b1;
        chk({tag, "_timeout"}, 64'(cyc < 3000), 64'd1);
        chk({tag, "_stray_pulse"}, 64'(stray), 64'd0);
        $display("sweep %s: %0d beats in %0d cycles", tag, got_q.size(), cyc);
    endtask

    task automatic compare_q(input string tag);
        chk({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d].ph",   tag, i), 64'(got_q[i].ph),   64'(exp_q[i].ph));
            chk($sformatf("%s[%0d].last", tag, i), 64'(got_q[i].last), 64'(exp_q[i].last));
            chk($sformatf("%s[%0d].sync", tag, i), 64'(got_q[i].sync), 64'(exp_q[i].sync));
            chk($sformatf("%s[%0d].done", tag, i), 64'(got_q[i].done), 64'(exp_q[i].done));
            chk($sformatf("%s[%0d].symb", tag, i), 64'(got_q[i].symb), 64'(exp_q[i].symb));
            chk($sformatf("%s[%0d].loc",  tag, i), 64'(got_q[i].loc),  64'(exp_q[i].loc));
            chk($sformatf("%s[%0d].idle", tag, i), 64'(got_q[i].idle), 64'(exp_q[i].idle));
        end
    endtask

    task automatic check_table(input string tag, input vec_t t[8]);
        chk({tag, "_tbl_beats"}, 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            chk($sformatf("%s_tbl[%0d].ph",   tag, i), 64'(got_q[i].ph),   64'(t[i].ph));
            chk($sformatf("%s_tbl[%0d].last", tag, i), 64'(got_q[i].last), 64'(t[i].last));
            chk($sformatf("%s_tbl[%0d].sync", tag, i), 64'(got_q[i].sync), 64'(t[i].sync));
            chk($sformatf("%s_tbl[%0d].done", tag, i), 64'(got_q[i].done), 64'(t[i].done));
        end
    endtask

    initial begin
        cfg_t c;
        vec_t t1[8];
        int   nsync, sa;

        t1[0] = '{24'd0,        1'b0, 1'b0, 1'b0};
        t1[1] = '{24'd4194304,  1'b0, 1'b0, 1'b0};
        t1[2] = '{24'd8388608,  1'b0, 1'b0, 1'b0};
        t1[3] = '{24'd12582912, 1'b1, 1'b0, 1'b0};
        t1[4] = '{24'd0,        1'b0, 1'b0, 1'b0};
        t1[5] = '{24'd4063232,  1'b0, 1'b0, 1'b0};
        t1[6] = '{24'd8126464,  1'b0, 1'b0, 1'b0};
        t1[7] = '{24'd12189696, 1'b1, 1'b1, 1'b1};

        // Reset state
        reset_n = 1'b0; srst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",   64'(busy),         64'd0);
        chk("rst_tvalid", 64'(phase_tvalid), 64'd0);
        chk("rst_tdata",  64'(phase_tdata),  64'd0);
        chk("rst_tlast",  64'(phase_tlast),  64'd0);
        chk("rst_sync",   64'(sync_ready),   64'd0);
        chk("rst_done",   64'(done),         64'd0);
        chk("rst_symb",   64'(symb_idx),     64'd0);
        chk("rst_loc",    64'(loc_idx),      64'd0);
        reset_n = 1'b1; srst = 1'b0;
        @(negedge clk);

        // 1: default increments, 2 symbols of 4 samples
        c = def_cfg(); c.nsig = 24'd4; c.nsymb = 16'd2; c.nloc = 3'd1;
        write_cfg(c);
        build_model(c, -1);
        run_sweep("t1", 1'b0, -1, 1'b0);
        check_table("t1", t1);
        compare_q("t1");

        // 2: same sweep under random backpressure
        run_sweep("t2", 1'b1, -1, 1'b0);
        check_table("t2", t1);
        compare_q("t2");

        // 3: inter-symbol gap, then back-to-back
        c = def_cfg(); c.nsig = 24'd2; c.nsymb = 16'd2; c.nloc = 3'd1; c.gap = 16'd3;
        write_cfg(c);
        build_model(c, -1);
        run_sweep("t3_gap", 1'b0, -1, 1'b0);
        compare_q("t3_gap");
        if (got_q.size() > 2) chk("t3_gap_idle", 64'(got_q[2].idle), 64'd3);
        c.gap = 16'd0;
        write_cfg(c);
        build_model(c, -1);
        run_sweep("t3_nogap", 1'b0, -1, 1'b0);
        compare_q("t3_nogap");

        // 4: stop at sample 1 of symbol 0
        c = def_cfg(); c.nsig = 24'd4; c.nsymb = 16'd2; c.nloc = 3'd1;
        write_cfg(c);
        build_model(c, 1);
        run_sweep("t4", 1'b0, 1, 1'b0);
        compare_q("t4");
        chk("t4_busy_after", 64'(busy), 64'd0);

        // 5: per-symbol base shift across two locations
        c = def_cfg(); c.nsig = 24'd2; c.nsymb = 16'd3; c.nloc = 3'd2; c.nsh = 24'd100;
        write_cfg(c);
        build_model(c, -1);
        run_sweep("t5", 1'b0, -1, 1'b0);
        compare_q("t5");
        nsync = 0;
        foreach (got_q[i]) nsync += int'(got_q[i].sync);
        chk("t5_sync_count", 64'(nsync), 64'd2);
        if (got_q.size() > 6) begin
            chk("t5_sym2_base", 64'(got_q[4].ph),  64'd16777016);
            chk("t5_loc1",      64'(got_q[6].loc), 64'd1);
        end

        // 6a: config write during busy only affects the next sweep
        c = def_cfg(); c.nsig = 24'd4; c.nsymb = 16'd2; c.nloc = 3'd1;
        write_cfg(c);
        build_model(c, -1);
        run_sweep("t6_busywr", 1'b0, -1, 1'b1);
        compare_q("t6_busywr");
        c.nsig = 24'd2;
        build_model(c, -1);
        run_sweep("t6_next", 1'b0, -1, 1'b0);
        compare_q("t6_next");

        // 6b: reset mid-sweep, then defaults in effect
        c = def_cfg(); c.start_ph = 24'd12345; c.nsig = 24'd4; c.nsymb = 16'd2; c.nloc = 3'd1;
        write_cfg(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_rst_tvalid", 64'(phase_tvalid), 64'd0);
        chk("t6_rst_busy",   64'(busy),         64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t6_def[%0d].valid", i), 64'(phase_tvalid), 64'd1);
            chk($sformatf("t6_def[%0d].ph", i),    64'(phase_tdata),  64'(i) * 64'd4194304);
            chk($sformatf("t6_def[%0d].last", i),  64'(phase_tlast),  64'd0);
            @(negedge clk);
        end
        $display("sweep t6_reset: 4 default beats observed");
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        #1;
        chk("t6_srst_busy", 64'(busy), 64'd0);
        @(negedge clk);

        // Random configurations under random backpressure, occasional stop
        for (int it = 0; it < 20; it++) begin
            c.start_ph = 24'($urandom);
            c.inc      = 24'($urandom);
            c.dph      = 24'($urandom);
            c.nsh      = 24'($urandom);
            c.nsig     = 24'($urandom_range(0, 4));
            c.nsymb    = 16'($urandom_range(0, 3));
            c.nloc     = 3'($urandom_range(0, 3));
            c.gap      = 16'($urandom_range(0, 2));
            write_cfg(c);
            build_model(c, -1);
            sa = -1;
            if ($urandom_range(0, 3) == 0) begin
                sa = int'($urandom_range(0, exp_q.size() - 1));
                build_model(c, sa);
            end
            run_sweep($sformatf("rnd%0d", it), 1'b1, sa, 1'b0);
            compare_q($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
